// File: rtl/nes_clk_pkg.sv
// rtl/nes_clk_pkg.sv - shared constants, state encoding and width helper for nes_clk_en_gen
//
// Purpose : NTSC divide constants, default channel geometry, FSM state
//           encoding and the channel-select width function.
// Ports   : none (package)
// Option  : CLK_EN_CYCLE_CNT_EN is consumed by nes_clk_en_gen, not here.
package nes_clk_pkg;

   localparam int NES_CPU_DIV = 12;
   localparam int NES_PPU_DIV = 4;
   localparam int NES_MST_HZ  = 21477272;

   localparam int NUM_CH_DEF  = 2;
   localparam int CNT_W_DEF   = 5;

   typedef enum logic [1:0] {
      ST_HALT  = 2'd0,
      ST_ALIGN = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   // A single channel still needs a one-bit select port.
   function automatic int ch_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/nes_clk_en_chan.sv
// rtl/nes_clk_en_chan.sv - one enable channel: divide counter, phase load, strobe and reset flops
//
// Purpose : Counts modulo div while stepping, emits a one-cycle enable when
//           the count is zero, and holds a reset that releases on the edge
//           after the first enable.
// Ports   : clk, rst          master clock, async active-high reset
//           div, phase        active divide and phase offset
//           load              realign: counter takes the phase load value
//           run_q             advance counter and evaluate strobe this edge
//           rst_set           force rst_en high (halting)
//           clk_en, rst_en    registered enable strobe and channel reset
module nes_clk_en_chan
   import nes_clk_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] div,
   input  logic [CNT_W-1:0] phase,
   input  logic             load,
   input  logic             run_q,
   input  logic             rst_set,
   output logic             clk_en,
   output logic             rst_en
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] load_val;

   // Starting div-phase steps before the wrap puts the first zero phase edges late.
   assign load_val = (phase == '0) ? '0 : (div - phase);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         clk_en <= 1'b0;
         rst_en <= 1'b1;
      end else begin
         if (load) begin
            cnt    <= load_val;
            clk_en <= 1'b0;
         end else if (run_q) begin
            clk_en <= (cnt == '0);
            cnt    <= (cnt == div - 1'b1) ? '0 : cnt + 1'b1;
         end else begin
            clk_en <= 1'b0;
         end

         // clk_en can only be high while the FSM stays in RUN, so it alone
         // marks the release edge.
         if (rst_set)
            rst_en <= 1'b1;
         else if (clk_en)
            rst_en <= 1'b0;
      end
   end

endmodule

// File: rtl/nes_clk_en_gen.sv
// rtl/nes_clk_en_gen.sv - multi-channel clock-enable generator with shadowed divide/phase config
//
// Purpose : HALT/ALIGN/RUN sequencer, shadow and active divide/phase
//           registers, config write handshake and commit, one
//           nes_clk_en_chan per channel.
// Ports   : clk_mst, rst_mst   master clock, async active-high reset
//           run                start/hold all channels
//           cfg_valid/ready    shadow write handshake (cfg_ch, cfg_div, cfg_phase)
//           cfg_commit         copy shadows to active and realign
//           cfg_err            one-cycle pulse after a rejected write
//           clk_en, rst_en     per-channel enable strobes and resets
//           en_cnt             per-channel 16-bit enable count (CLK_EN_CYCLE_CNT_EN only)
// Option  : define CLK_EN_CYCLE_CNT_EN to add en_cnt.
module nes_clk_en_gen
   import nes_clk_pkg::*;
#(
   parameter int                      NUM_CH     = NUM_CH_DEF,
   parameter int                      CNT_W      = CNT_W_DEF,
   parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT   = {5'd4, 5'd12},
   parameter logic [NUM_CH*CNT_W-1:0] PHASE_INIT = {5'd0, 5'd0}
) (
   input  logic                      clk_mst,
   input  logic                      rst_mst,
   input  logic                      run,
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic [ch_w(NUM_CH)-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]          cfg_div,
   input  logic [CNT_W-1:0]          cfg_phase,
   input  logic                      cfg_commit,
   output logic                      cfg_err,
`ifdef CLK_EN_CYCLE_CNT_EN
   output logic [NUM_CH*16-1:0]      en_cnt,
`endif
   output logic [NUM_CH-1:0]         clk_en,
   output logic [NUM_CH-1:0]         rst_en
);

   state_t state;

   logic [NUM_CH-1:0][CNT_W-1:0] shd_div, shd_ph;
   logic [NUM_CH-1:0][CNT_W-1:0] act_div, act_ph;
   logic [NUM_CH-1:0][CNT_W-1:0] shd_div_nxt, shd_ph_nxt;

   logic wr_fire, wr_bad, wr_ok, commit_ok;
   logic step, load, rst_set;

   assign wr_fire = cfg_valid && cfg_ready;
   assign wr_bad  = (cfg_div == '0) || (cfg_phase >= cfg_div) || (int'(cfg_ch) >= NUM_CH);
   assign wr_ok   = wr_fire && !wr_bad;

   // Shadow view including this cycle's write, so a same-cycle commit sees it.
   always_comb begin
      shd_div_nxt = shd_div;
      shd_ph_nxt  = shd_ph;
      if (wr_ok) begin
         shd_div_nxt[cfg_ch] = cfg_div;
         shd_ph_nxt[cfg_ch]  = cfg_phase;
      end
   end

   assign commit_ok = cfg_commit && (state != ST_ALIGN);

   // Channels step only when staying in RUN; a commit or run drop freezes
   // them and forces the strobes low on that edge.
   assign step    = (state == ST_RUN) && run && !cfg_commit;
   assign load    = (state == ST_ALIGN);
   assign rst_set = (state == ST_HALT) || !run;

   always_ff @(posedge clk_mst or posedge rst_mst) begin
      if (rst_mst) begin
         state     <= ST_HALT;
         cfg_ready <= 1'b0;
         cfg_err   <= 1'b0;
         shd_div   <= DIV_INIT;
         shd_ph    <= PHASE_INIT;
         act_div   <= DIV_INIT;
         act_ph    <= PHASE_INIT;
      end else begin
         cfg_err   <= wr_fire && wr_bad;
         shd_div   <= shd_div_nxt;
         shd_ph    <= shd_ph_nxt;
         cfg_ready <= 1'b1;
         if (commit_ok) begin
            act_div <= shd_div_nxt;
            act_ph  <= shd_ph_nxt;
         end
         case (state)
            ST_HALT: begin
               if (run) begin
                  state     <= ST_ALIGN;
                  cfg_ready <= 1'b0;
               end
            end
            ST_ALIGN: begin
               state <= run ? ST_RUN : ST_HALT;
            end
            ST_RUN: begin
               if (!run) begin
                  state <= ST_HALT;
               end else if (cfg_commit) begin
                  state     <= ST_ALIGN;
                  cfg_ready <= 1'b0;
               end
            end
            default: begin
               state <= ST_HALT;
            end
         endcase
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      nes_clk_en_chan #(
         .CNT_W (CNT_W)
      ) u_chan (
         .clk     (clk_mst),
         .rst     (rst_mst),
         .div     (act_div[i]),
         .phase   (act_ph[i]),
         .load    (load),
         .run_q   (step),
         .rst_set (rst_set),
         .clk_en  (clk_en[i]),
         .rst_en  (rst_en[i])
      );

`ifdef CLK_EN_CYCLE_CNT_EN
      logic [15:0] cnt_r;

      always_ff @(posedge clk_mst or posedge rst_mst) begin
         if (rst_mst)
            cnt_r <= '0;
         else if (state == ST_HALT)
            cnt_r <= '0;
         else if (clk_en[i])
            cnt_r <= cnt_r + 16'd1;
      end

      assign en_cnt[i*16 +: 16] = cnt_r;
`endif
   end

endmodule
